mapping_req_arbiter: RTL and testbench

Shares the hashed-paging mapping core between the read-request and write-request AXI-Stream channels. Each cycle it picks one of the two channels round-robin and issues that request through a registered output stage to the core. It keeps an in-order FIFO of request types, which it uses to steer the core's single in-order response stream back to `out_read` or `out_write`. It sits between the system-side request channels and the mapping core, in front of the DDR4-backed hash table.

---
 rtl/mapping_req_arbiter_pkg.sv | 15 +
 rtl/mapping_req_arbiter_if.sv | 16 +
 rtl/mapping_req_arbiter_order_fifo.sv | 47 ++++
 rtl/mapping_req_arbiter.sv | 120 ++++++++++++
 tb/tb_mapping_req_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mapping_req_arbiter_pkg.sv
// Shared definitions for the mapping-core request arbiter: word width,
// request-type codes and the request record used on the core side.
package mapping_pkg;

   localparam int DATA_W = 73;

   localparam logic REQ_READ  = 1'b0;
   localparam logic REQ_WRITE = 1'b1;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              kind;
   } map_req_t;

endpackage

// File: rtl/mapping_req_arbiter_if.sv
// Plain valid/ready stream used for every request and response channel
// around the mapping core.
interface mapping_req_arbiter_if
   import mapping_pkg::*;
#(
   parameter int W = DATA_W
) ();

   logic [W-1:0] tdata;
   logic         tvalid;
   logic         tready;

   modport master (output tdata, output tvalid, input tready);
   modport slave  (input tdata, input tvalid, output tready);

endinterface

// File: rtl/mapping_req_arbiter_order_fifo.sv
// One-bit in-order FIFO recording the type of each issued request so the
// core's response stream can be steered back to the right channel.
module mapping_order_fifo #(
   parameter int DEPTH = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic push,
   input  logic din,
   input  logic pop,
   output logic dout,
   output logic empty,
   output logic full
);

   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0] mem;
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;

   // The extra pointer bit tells a full FIFO apart from an empty one.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mapping_req_arbiter.sv
// Round-robin arbiter sharing the mapping core between read and write request
// streams, with a registered issue stage and in-order response steering.
module mapping_req_arbiter #(
   parameter int DATA_W          = mapping_pkg::DATA_W,
   parameter int MAX_OUTSTANDING = 16,
   parameter int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   input  logic                   enable,
   mapping_req_arbiter_if.slave   in_read,
   mapping_req_arbiter_if.slave   in_write,
   mapping_req_arbiter_if.master  req,
   output logic                   req_tuser,
   mapping_req_arbiter_if.slave   rsp,
   mapping_req_arbiter_if.master  out_read,
   mapping_req_arbiter_if.master  out_write,
   output logic [CNT_W-1:0]       outstanding,
   output logic                   err_orphan_rsp
);

   import mapping_pkg::*;

   logic              slot_free;
   logic              can_issue;
   logic              grant;
   logic              rr_ptr;
   logic              read_take;
   logic              write_take;
   logic              accept;
   logic              rsp_ready;
   logic              rsp_fire;
   logic              fifo_head;
   logic              fifo_empty;
   logic              fifo_full;
   logic [DATA_W-1:0] req_data_q;
   logic              req_user_q;
   logic              req_valid_q;

   // Credit check uses the registered count, so a response only frees a slot
   // for acceptance in the following cycle.
   assign slot_free = !req_valid_q || req.tready;
   assign can_issue = !sys_rst && enable && slot_free && !fifo_full &&
                      (outstanding < CNT_W'(MAX_OUTSTANDING));

   always_comb begin
      grant = rr_ptr;
      if (in_read.tvalid && !in_write.tvalid) begin
         grant = REQ_READ;
      end else if (in_write.tvalid && !in_read.tvalid) begin
         grant = REQ_WRITE;
      end
   end

   assign read_take      = can_issue && in_read.tvalid  && (grant == REQ_READ);
   assign write_take     = can_issue && in_write.tvalid && (grant == REQ_WRITE);
   assign accept         = read_take || write_take;
   assign in_read.tready  = read_take;
   assign in_write.tready = write_take;

   assign req.tdata  = req_data_q;
   assign req.tvalid = req_valid_q;
   assign req_tuser  = req_user_q;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         req_data_q  <= '0;
         req_user_q  <= REQ_READ;
         req_valid_q <= 1'b0;
         rr_ptr      <= REQ_READ;
      end else if (accept) begin
         req_data_q  <= (grant == REQ_WRITE) ? in_write.tdata : in_read.tdata;
         req_user_q  <= grant;
         req_valid_q <= 1'b1;
         rr_ptr      <= ~grant;
      end else if (req.tready) begin
         req_valid_q <= 1'b0;
      end
   end

   // Responses come back in issue order; the FIFO head names their owner.
   assign out_read.tdata   = rsp.tdata;
   assign out_write.tdata  = rsp.tdata;
   assign out_read.tvalid  = rsp.tvalid && !fifo_empty && (fifo_head == REQ_READ);
   assign out_write.tvalid = rsp.tvalid && !fifo_empty && (fifo_head == REQ_WRITE);
   assign rsp_ready = !fifo_empty &&
                      ((fifo_head == REQ_READ) ? out_read.tready : out_write.tready);
   assign rsp.tready = rsp_ready;
   assign rsp_fire   = rsp.tvalid && rsp_ready;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         outstanding    <= '0;
         err_orphan_rsp <= 1'b0;
      end else begin
         if (accept && !rsp_fire) begin
            outstanding <= outstanding + CNT_W'(1);
         end else if (rsp_fire && !accept) begin
            outstanding <= outstanding - CNT_W'(1);
         end
         if (rsp.tvalid && fifo_empty) begin
            err_orphan_rsp <= 1'b1;
         end
      end
   end

   mapping_order_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) order_fifo (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .push  (accept),
      .din   (grant),
      .pop   (rsp_fire),
      .dout  (fifo_head),
      .empty (fifo_empty),
      .full  (fifo_full)
   );

endmodule

// File: tb/tb_mapping_req_arbiter.sv
// Self-checking bench for mapping_req_arbiter: directed scenarios followed by
// random traffic, all compared against a queue-based reference model.
module tb_mapping_req_arbiter;

   import mapping_pkg::*;

   localparam int MAX_OUT = 16;
   localparam int CNT_W   = $clog2(MAX_OUT) + 1;

   logic             sys_clk = 1'b0;
   logic             sys_rst;
   logic             enable;
   logic             req_tuser;
   logic [CNT_W-1:0] outstanding;
   logic             err_orphan_rsp;

   mapping_req_arbiter_if #(.W(DATA_W)) in_read_ch ();
   mapping_req_arbiter_if #(.W(DATA_W)) in_write_ch ();
   mapping_req_arbiter_if #(.W(DATA_W)) req_ch ();
   mapping_req_arbiter_if #(.W(DATA_W)) rsp_ch ();
   mapping_req_arbiter_if #(.W(DATA_W)) out_read_ch ();
   mapping_req_arbiter_if #(.W(DATA_W)) out_write_ch ();

   mapping_req_arbiter #(
      .DATA_W          (DATA_W),
      .MAX_OUTSTANDING (MAX_OUT)
   ) dut (
      .sys_clk        (sys_clk),
      .sys_rst        (sys_rst),
      .enable         (enable),
      .in_read        (in_read_ch),
      .in_write       (in_write_ch),
      .req            (req_ch),
      .req_tuser      (req_tuser),
      .rsp            (rsp_ch),
      .out_read       (out_read_ch),
      .out_write      (out_write_ch),
      .outstanding    (outstanding),
      .err_orphan_rsp (err_orphan_rsp)
   );

   always #5 sys_clk = ~sys_clk;

   int total = 0;
   int bad   = 0;

   // Reference model: the request held for the core, the owner order of
   // everything in flight, and what the core has actually received.
   map_req_t          m_req;
   logic              m_valid;
   logic              m_rr;
   logic              m_err;
   int                m_count;
   logic              order_q[$];
   logic [DATA_W-1:0] core_q[$];

   logic              obs_log[$];
   logic [DATA_W-1:0] rd_rx[$];
   logic [DATA_W-1:0] wr_rx[$];
   logic              last_rsp_ready;

   task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DATA_W-1:0] rand_word();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[DATA_W-1:0];
   endfunction

   task automatic do_reset();
      sys_rst = 1'b1;
      in_read_ch.tvalid   = 1'b0;
      in_read_ch.tdata    = '0;
      in_write_ch.tvalid  = 1'b0;
      in_write_ch.tdata   = '0;
      req_ch.tready       = 1'b0;
      rsp_ch.tvalid       = 1'b0;
      rsp_ch.tdata        = '0;
      out_read_ch.tready  = 1'b0;
      out_write_ch.tready = 1'b0;
      @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
      m_req   = '0;
      m_valid = 1'b0;
      m_rr    = REQ_READ;
      m_err   = 1'b0;
      m_count = 0;
      order_q.delete();
      core_q.delete();
   endtask

   // One clock of stimulus: drive, compare against the model, clock, advance model.
   task automatic apply_stimulus(
      input  logic rv, input logic [DATA_W-1:0] rd,
      input  logic wv, input logic [DATA_W-1:0] wd,
      input  logic qr,
      input  logic sv, input logic [DATA_W-1:0] sd,
      input  logic ort, input logic owt,
      output logic rd_acc, output logic wr_acc);
      logic can, g, ne, hd, exp_rsp_ready, fire;
      in_read_ch.tvalid   = rv;
      in_read_ch.tdata    = rd;
      in_write_ch.tvalid  = wv;
      in_write_ch.tdata   = wd;
      req_ch.tready       = qr;
      rsp_ch.tvalid       = sv;
      rsp_ch.tdata        = sd;
      out_read_ch.tready  = ort;
      out_write_ch.tready = owt;
      #1;
      can = enable && (!m_valid || qr) && (m_count < MAX_OUT);
      if (rv && !wv)      g = REQ_READ;
      else if (wv && !rv) g = REQ_WRITE;
      else                g = m_rr;
      rd_acc = can && rv && (g == REQ_READ);
      wr_acc = can && wv && (g == REQ_WRITE);
      ne = (order_q.size() > 0);
      hd = ne ? order_q[0] : REQ_READ;
      exp_rsp_ready = ne && ((hd == REQ_READ) ? ort : owt);

      if (rv || wv) begin
         check_output("in_read_tready", in_read_ch.tready, rd_acc);
         check_output("in_write_tready", in_write_ch.tready, wr_acc);
      end
      check_output("req_tvalid", req_ch.tvalid, m_valid);
      check_output("req_tdata", req_ch.tdata, m_req.data);
      check_output("req_tuser", req_tuser, m_req.kind);
      check_output("outstanding", outstanding, m_count);
      check_output("err_orphan_rsp", err_orphan_rsp, m_err);
      check_output("out_read_tvalid", out_read_ch.tvalid, sv && ne && (hd == REQ_READ));
      check_output("out_write_tvalid", out_write_ch.tvalid, sv && ne && (hd == REQ_WRITE));
      check_output("rsp_tready", rsp_ch.tready, exp_rsp_ready);
      check_output("out_read_tdata", out_read_ch.tdata, sd);
      check_output("out_write_tdata", out_write_ch.tdata, sd);

      last_rsp_ready = rsp_ch.tready;
      if (req_ch.tvalid && qr) obs_log.push_back(req_tuser);
      if (out_read_ch.tvalid && ort) rd_rx.push_back(out_read_ch.tdata);
      if (out_write_ch.tvalid && owt) wr_rx.push_back(out_write_ch.tdata);

      @(posedge sys_clk);
      fire = sv && exp_rsp_ready;
      if (m_valid && qr) core_q.push_back(m_req.data);
      if (rd_acc || wr_acc) begin
         m_req.data = (g == REQ_WRITE) ? wd : rd;
         m_req.kind = g;
         m_valid    = 1'b1;
         order_q.push_back(g);
         m_rr       = ~g;
         m_count++;
      end else if (qr) begin
         m_valid = 1'b0;
      end
      if (fire) begin
         void'(order_q.pop_front());
         if (core_q.size() > 0) void'(core_q.pop_front());
         m_count--;
      end
      if (sv && !ne) m_err = 1'b1;
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic ra, wa;
      int   ri, wi, guard;
      logic [DATA_W-1:0] sd;

      enable = 1'b1;
      last_rsp_ready = 1'b0;
      do_reset();
      do_reset();

      $display("[TB] reset values");
      check_output("rst_req_tvalid", req_ch.tvalid, 1'b0);
      check_output("rst_req_tdata", req_ch.tdata, '0);
      check_output("rst_req_tuser", req_tuser, 1'b0);
      check_output("rst_in_read_tready", in_read_ch.tready, 1'b0);
      check_output("rst_in_write_tready", in_write_ch.tready, 1'b0);
      check_output("rst_rsp_tready", rsp_ch.tready, 1'b0);
      check_output("rst_outstanding", outstanding, 0);
      check_output("rst_err", err_orphan_rsp, 1'b0);

      $display("[TB] alternating contention");
      obs_log.delete();
      ri = 0; wi = 0;
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(1'b1, DATA_W'(1 + ri), 1'b1, DATA_W'(32'h100 + wi), 1'b1,
                        1'b0, '0, 1'b1, 1'b1, ra, wa);
         if (ra) ri++;
         if (wa) wi++;
      end
      apply_stimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b1, ra, wa);
      check_output("alt_issue_count", obs_log.size(), 8);
      for (int i = 0; i < 8; i++) check_output("alt_tuser", obs_log[i], i % 2);
      check_output("alt_outstanding", outstanding, 8);

      $display("[TB] single source");
      do_reset();
      obs_log.delete();
      for (int i = 0; i < 5; i++)
         apply_stimulus(1'b0, '0, 1'b1, DATA_W'(32'h200 + i), 1'b1,
                        1'b0, '0, 1'b1, 1'b1, ra, wa);
      apply_stimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b1, ra, wa);
      check_output("single_issue_count", obs_log.size(), 5);
      for (int i = 0; i < 5; i++) check_output("single_tuser", obs_log[i], 1'b1);

      $display("[TB] credit limit");
      do_reset();
      ri = 0;
      for (int i = 0; i < 20; i++) begin
         apply_stimulus(1'b1, DATA_W'(32'h300 + ri), 1'b0, '0, 1'b1,
                        1'b0, '0, 1'b1, 1'b1, ra, wa);
         if (ra) ri++;
      end
      check_output("credit_saturated", outstanding, 16);
      check_output("credit_blocked", in_read_ch.tready, 1'b0);
      sd = core_q[0];
      apply_stimulus(1'b1, DATA_W'(32'h300 + ri), 1'b0, '0, 1'b1,
                     1'b1, sd, 1'b1, 1'b1, ra, wa);
      check_output("credit_reopen", in_read_ch.tready, 1'b1);
      apply_stimulus(1'b1, DATA_W'(32'h300 + ri), 1'b0, '0, 1'b1,
                     1'b0, '0, 1'b1, 1'b1, ra, wa);
      check_output("credit_refill", outstanding, 16);
      check_output("credit_reblocked", in_read_ch.tready, 1'b0);

      $display("[TB] response routing");
      do_reset();
      rd_rx.delete(); wr_rx.delete();
      apply_stimulus(1'b1, DATA_W'(32'h41), 1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b1, ra, wa);
      apply_stimulus(1'b0, '0, 1'b1, DATA_W'(32'h42), 1'b1, 1'b0, '0, 1'b1, 1'b1, ra, wa);
      apply_stimulus(1'b1, DATA_W'(32'h43), 1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b1, ra, wa);
      apply_stimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b1, ra, wa);
      apply_stimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, DATA_W'(32'hA), 1'b1, 1'b1, ra, wa);
      apply_stimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, DATA_W'(32'hB), 1'b1, 1'b1, ra, wa);
      apply_stimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, DATA_W'(32'hC), 1'b1, 1'b1, ra, wa);
      check_output("route_read_count", rd_rx.size(), 2);
      check_output("route_read_first", rd_rx[0], 32'hA);
      check_output("route_read_second", rd_rx[1], 32'hC);
      check_output("route_write_count", wr_rx.size(), 1);
      check_output("route_write_first", wr_rx[0], 32'hB);
      check_output("route_drained", outstanding, 0);

      $display("[TB] write-side stall");
      do_reset();
      apply_stimulus(1'b0, '0, 1'b1, DATA_W'(32'h51), 1'b1, 1'b0, '0, 1'b1, 1'b1, ra, wa);
      apply_stimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b1, ra, wa);
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, DATA_W'(32'hB), 1'b1, 1'b0, ra, wa);
         check_output("stall_rsp_tready", last_rsp_ready, 1'b0);
      end
      apply_stimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, DATA_W'(32'hB), 1'b1, 1'b1, ra, wa);
      check_output("stall_release", last_rsp_ready, 1'b1);

      $display("[TB] simultaneous issue and return");
      do_reset();
      for (int i = 0; i < 5; i++)
         apply_stimulus(1'b1, DATA_W'(32'h60 + i), 1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b1, ra, wa);
      apply_stimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b1, ra, wa);
      check_output("simul_before", outstanding, 5);
      sd = core_q[0];
      apply_stimulus(1'b1, DATA_W'(32'h70), 1'b0, '0, 1'b1, 1'b1, sd, 1'b1, 1'b1, ra, wa);
      check_output("simul_after", outstanding, 5);

      $display("[TB] orphan response and mid-run reset");
      do_reset();
      apply_stimulus(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, DATA_W'(32'h55), 1'b1, 1'b1, ra, wa);
      check_output("orphan_rsp_tready", last_rsp_ready, 1'b0);
      check_output("orphan_err", err_orphan_rsp, 1'b1);
      for (int i = 0; i < 3; i++)
         apply_stimulus(1'b1, DATA_W'(32'h80 + i), 1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b1, ra, wa);
      check_output("pre_reset_outstanding", outstanding, 3);
      do_reset();
      rsp_ch.tvalid = 1'b1;
      in_read_ch.tvalid = 1'b0;
      in_write_ch.tvalid = 1'b0;
      #1;
      check_output("mid_rst_req_tvalid", req_ch.tvalid, 1'b0);
      check_output("mid_rst_req_tdata", req_ch.tdata, '0);
      check_output("mid_rst_req_tuser", req_tuser, 1'b0);
      check_output("mid_rst_outstanding", outstanding, 0);
      check_output("mid_rst_err", err_orphan_rsp, 1'b0);
      check_output("mid_rst_rsp_tready", rsp_ch.tready, 1'b0);
      check_output("mid_rst_out_read_tvalid", out_read_ch.tvalid, 1'b0);
      check_output("mid_rst_out_write_tvalid", out_write_ch.tvalid, 1'b0);
      rsp_ch.tvalid = 1'b0;
      #1;

      $display("[TB] random traffic");
      do_reset();
      for (int i = 0; i < 500; i++) begin
         logic sv;
         enable = ($urandom_range(0, 9) != 0);
         sv = (core_q.size() > 0) && ($urandom_range(0, 1) == 1);
         sd = sv ? (core_q[0] ^ DATA_W'(32'h5A5A)) : rand_word();
         apply_stimulus(1'($urandom_range(0, 1)), rand_word(),
                        1'($urandom_range(0, 1)), rand_word(),
                        ($urandom_range(0, 3) != 0), sv, sd,
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, wa);
      end
      enable = 1'b1;
      guard = 0;
      while ((order_q.size() > 0) && (guard < 200)) begin
         logic sv;
         sv = (core_q.size() > 0);
         sd = sv ? core_q[0] : '0;
         apply_stimulus(1'b0, '0, 1'b0, '0, 1'b1, sv, sd, 1'b1, 1'b1, ra, wa);
         guard++;
      end
      check_output("random_drain_bound", guard < 200, 1'b1);
      check_output("random_drained", outstanding, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
